regfile_read_scheduler: RTL and testbench

Read-side front end for the multiport BRAM register file. Accepts up to READ_PORTS independent register read requests per cycle and schedules them onto the BANK_PORTS physical BRAM read ports with round-robin fairness. It tracks the fixed BRAM read latency in a shift pipeline and returns each result to its requester, tagged by port position. It sits between the issue/operand-fetch stage and the register-file BRAM banks, and mirrors the write path that drives those banks.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/rr_multi_grant_arbiter.sv | 50 +++++
 rtl/regfile_read_scheduler.sv | 159 +++++++++++++++
 tb/tb_regfile_read_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file read scheduler.
// Optional snoop bypass fields are present only when REGFILE_RD_BYPASS_EN is defined.
package regfile_pkg;

    // Index width that stays at least one bit wide for single-entry ranges
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned RF_DATA_WIDTH  = 64;
    localparam int unsigned RF_REG_COUNT   = 256;
    localparam int unsigned RF_ADDR_WIDTH  = addr_width(RF_REG_COUNT);
    localparam int unsigned RF_READ_PORTS  = 8;
    localparam int unsigned RF_BANK_PORTS  = 2;
    localparam int unsigned RF_WRITE_PORTS = 4;
    localparam int unsigned RF_RAM_LATENCY = 2;

    localparam int unsigned ID_WIDTH   = $clog2(RF_READ_PORTS);
    localparam int unsigned PORT_WIDTH = addr_width(RF_BANK_PORTS);

    // One in-flight BRAM read
    typedef struct packed {
        logic                     valid;
        logic [ID_WIDTH-1:0]      id;
        logic [RF_ADDR_WIDTH-1:0] addr;
`ifdef REGFILE_RD_BYPASS_EN
        logic                     bypass_hit;
        logic [RF_DATA_WIDTH-1:0] bypass_data;
`endif
    } pipe_entry_t;

endpackage

// File: rtl/rr_multi_grant_arbiter.sv
// Round-robin arbiter granting up to NUM_PORTS requesters per cycle.
// The k-th grant in scan order (starting at rr_ptr_i) is mapped to port k.
// Not affected by REGFILE_RD_BYPASS_EN.
module rr_multi_grant_arbiter #(
    parameter int unsigned NUM_REQ   = 8,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned PORT_W    = 1
) (
    input  logic [NUM_REQ-1:0]        valid_i,
    input  logic [ID_W-1:0]           rr_ptr_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_PORTS-1:0]      port_valid_o,
    output logic [NUM_PORTS*ID_W-1:0] port_id_o,
    output logic [ID_W-1:0]           next_ptr_o
);

    logic [NUM_PORTS-1:0][ID_W-1:0] port_id;
    logic [ID_W-1:0]                idx;
    int unsigned                    pos;
    int unsigned                    nxt;
    int unsigned                    cnt;

    // Wrapping scan from rr_ptr_i; pointer moves past the last grant
    always_comb begin
        grant_o      = '0;
        port_valid_o = '0;
        port_id      = '0;
        next_ptr_o   = rr_ptr_i;
        idx          = '0;
        pos          = 0;
        nxt          = 0;
        cnt          = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = (32'(rr_ptr_i) + i) % NUM_REQ;
            idx = ID_W'(pos);
            if (valid_i[idx] && (cnt < NUM_PORTS)) begin
                grant_o[idx]                = 1'b1;
                port_valid_o[PORT_W'(cnt)]  = 1'b1;
                port_id[PORT_W'(cnt)]       = idx;
                nxt                         = (pos + 1) % NUM_REQ;
                next_ptr_o                  = ID_W'(nxt);
                cnt                         = cnt + 1;
            end
        end
    end

    assign port_id_o = port_id;

endmodule

// File: rtl/regfile_read_scheduler.sv
// Read-side scheduler for the multiport BRAM register file: arbitrates
// requesters onto bank ports, tracks BRAM latency and routes responses.
// Define REGFILE_RD_BYPASS_EN to forward snooped writes that land after issue.
module regfile_read_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = RF_DATA_WIDTH,
    parameter int unsigned REG_COUNT   = RF_REG_COUNT,
    parameter int unsigned ADDR_WIDTH  = addr_width(REG_COUNT),
    parameter int unsigned READ_PORTS  = RF_READ_PORTS,
    parameter int unsigned BANK_PORTS  = RF_BANK_PORTS,
    parameter int unsigned WRITE_PORTS = RF_WRITE_PORTS,
    parameter int unsigned RAM_LATENCY = RF_RAM_LATENCY
) (
    input  logic                              clk_i,
    input  logic                              sync_rst_i,
    input  logic                              clk_en_i,
    input  logic [READ_PORTS-1:0]             req_valid_i,
    input  logic [ADDR_WIDTH*READ_PORTS-1:0]  req_addr_i,
    output logic [READ_PORTS-1:0]             req_ready_o,
    output logic [BANK_PORTS-1:0]             ram_rd_en_o,
    output logic [ADDR_WIDTH*BANK_PORTS-1:0]  ram_addr_o,
    input  logic [DATA_WIDTH*BANK_PORTS-1:0]  ram_rd_data_i,
    input  logic [WRITE_PORTS-1:0]            snoop_wr_en_i,
    input  logic [ADDR_WIDTH*WRITE_PORTS-1:0] snoop_wr_addr_i,
    input  logic [DATA_WIDTH*WRITE_PORTS-1:0] snoop_wr_data_i,
    output logic [READ_PORTS-1:0]             rsp_valid_o,
    output logic [DATA_WIDTH*READ_PORTS-1:0]  rsp_data_o
);

    localparam int unsigned IDW = addr_width(READ_PORTS);
    localparam int unsigned PW  = addr_width(BANK_PORTS);

    logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr_a;
    logic [BANK_PORTS-1:0][ADDR_WIDTH-1:0]  ram_addr_a;
    logic [BANK_PORTS-1:0][DATA_WIDTH-1:0]  ram_rd_data_a;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rsp_data_a;

    logic                                   advance;
    logic [READ_PORTS-1:0]                  arb_valid;
    logic [READ_PORTS-1:0]                  grant;
    logic [BANK_PORTS-1:0]                  port_valid;
    logic [BANK_PORTS-1:0][IDW-1:0]         port_id_a;
    logic [IDW-1:0]                         rr_ptr_q;
    logic [IDW-1:0]                         rr_ptr_d;

    pipe_entry_t [RAM_LATENCY-1:0][BANK_PORTS-1:0] pipe_q;
    pipe_entry_t [RAM_LATENCY-1:0][BANK_PORTS-1:0] pipe_d;

    assign req_addr_a    = req_addr_i;
    assign ram_rd_data_a = ram_rd_data_i;

    // Nothing is granted while stalled or in reset
    assign advance   = clk_en_i && !sync_rst_i;
    assign arb_valid = req_valid_i & {READ_PORTS{advance}};

    rr_multi_grant_arbiter #(
        .NUM_REQ   (READ_PORTS),
        .NUM_PORTS (BANK_PORTS),
        .ID_W      (IDW),
        .PORT_W    (PW)
    ) u_arb (
        .valid_i      (arb_valid),
        .rr_ptr_i     (rr_ptr_q),
        .grant_o      (grant),
        .port_valid_o (port_valid),
        .port_id_o    (port_id_a),
        .next_ptr_o   (rr_ptr_d)
    );

    assign req_ready_o = grant;
    assign ram_rd_en_o = port_valid;

    // Route each granted requester's address onto its bank port
    always_comb begin
        ram_addr_a = '0;
        for (int unsigned k = 0; k < BANK_PORTS; k++) begin
            if (port_valid[k]) begin
                ram_addr_a[k] = req_addr_a[port_id_a[k]];
            end
        end
    end

    assign ram_addr_o = ram_addr_a;

`ifdef REGFILE_RD_BYPASS_EN
    logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] snoop_addr_a;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] snoop_data_a;
    assign snoop_addr_a = snoop_wr_addr_i;
    assign snoop_data_a = snoop_wr_data_i;
`else
    logic unused_snoop;
    assign unused_snoop = ^{snoop_wr_en_i, snoop_wr_addr_i, snoop_wr_data_i};
`endif

    // Stage 0 takes new issues; later stages shift, capturing matching writes
    always_comb begin
        pipe_d = '0;
        for (int unsigned k = 0; k < BANK_PORTS; k++) begin
            pipe_d[0][k].valid = port_valid[k];
            pipe_d[0][k].id    = ID_WIDTH'(port_id_a[k]);
            pipe_d[0][k].addr  = RF_ADDR_WIDTH'(ram_addr_a[k]);
        end
        for (int unsigned s = 1; s < RAM_LATENCY; s++) begin
            for (int unsigned k = 0; k < BANK_PORTS; k++) begin
                pipe_d[s][k] = pipe_q[s-1][k];
`ifdef REGFILE_RD_BYPASS_EN
                for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
                    if (pipe_q[s-1][k].valid && snoop_wr_en_i[w] &&
                        (RF_ADDR_WIDTH'(snoop_addr_a[w]) == pipe_q[s-1][k].addr)) begin
                        pipe_d[s][k].bypass_hit  = 1'b1;
                        pipe_d[s][k].bypass_data = RF_DATA_WIDTH'(snoop_data_a[w]);
                    end
                end
`endif
            end
        end
    end

    // Pipeline and pointer advance only on enabled cycles; reset drops in-flight reads
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            rr_ptr_q <= '0;
            pipe_q   <= '0;
        end else if (clk_en_i) begin
            rr_ptr_q <= rr_ptr_d;
            pipe_q   <= pipe_d;
        end
    end

    // Final stage returns BRAM data, or the captured write when a bypass hit
    always_comb begin
        rsp_valid_o = '0;
        rsp_data_a  = '0;
        if (advance) begin
            for (int unsigned k = 0; k < BANK_PORTS; k++) begin
                if (pipe_q[RAM_LATENCY-1][k].valid) begin
                    rsp_valid_o[pipe_q[RAM_LATENCY-1][k].id] = 1'b1;
                    rsp_data_a[pipe_q[RAM_LATENCY-1][k].id]  = ram_rd_data_a[k];
`ifdef REGFILE_RD_BYPASS_EN
                    if (pipe_q[RAM_LATENCY-1][k].bypass_hit) begin
                        rsp_data_a[pipe_q[RAM_LATENCY-1][k].id] =
                            DATA_WIDTH'(pipe_q[RAM_LATENCY-1][k].bypass_data);
                    end
`endif
                end
            end
        end
    end

    assign rsp_data_o = rsp_data_a;

    // The last stage's address has no further consumer
    logic [BANK_PORTS-1:0] unused_tail_addr;
    for (genvar k = 0; k < BANK_PORTS; k++) begin : g_tail
        assign unused_tail_addr[k] = ^pipe_q[RAM_LATENCY-1][k].addr;
    end

endmodule

// File: tb/tb_regfile_read_scheduler.sv
// Directed bench for regfile_read_scheduler with a 2-cycle BRAM model.
// Bypass expectation follows REGFILE_RD_BYPASS_EN.
module tb_regfile_read_scheduler;

    logic             clk;
    logic             sync_rst;
    logic             clk_en;
    logic [7:0]       req_valid;
    logic [7:0][7:0]  ra;
    logic [7:0]       req_ready;
    logic [1:0]       ram_rd_en;
    logic [1:0][7:0]  ram_addr;
    logic [1:0][63:0] d1;
    logic [1:0][63:0] d2;
    logic [3:0]       snoop_wr_en;
    logic [3:0][7:0]  snoop_wr_addr;
    logic [3:0][63:0] snoop_wr_data;
    logic [7:0]       rsp_valid;
    logic [7:0][63:0] rsp_data;

    int total = 0;
    int bad   = 0;

    regfile_read_scheduler dut (
        .clk_i           (clk),
        .sync_rst_i      (sync_rst),
        .clk_en_i        (clk_en),
        .req_valid_i     (req_valid),
        .req_addr_i      (ra),
        .req_ready_o     (req_ready),
        .ram_rd_en_o     (ram_rd_en),
        .ram_addr_o      (ram_addr),
        .ram_rd_data_i   (d2),
        .snoop_wr_en_i   (snoop_wr_en),
        .snoop_wr_addr_i (snoop_wr_addr),
        .snoop_wr_data_i (snoop_wr_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_f(input logic [7:0] a);
        case (a)
            8'h10:   return 64'hDEAD;
            8'h20:   return 64'h1;
            default: return 64'h1000 + 64'(a);
        endcase
    endfunction

    // BRAM read pipeline sharing the clock enable
    always @(posedge clk) begin
        if (clk_en) begin
            d1[0] <= mem_f(ram_addr[0]);
            d1[1] <= mem_f(ram_addr[1]);
            d2    <= d1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_rst  = 1'b1;
        req_valid = 8'h00;
        tick();
        tick();
        sync_rst  = 1'b0;
    endtask

    logic [7:0]  exp_g;
    logic [7:0]  lo;
    logic [63:0] exp_byp;

    initial begin
        sync_rst      = 1'b1;
        clk_en        = 1'b1;
        req_valid     = 8'hFF;
        ra            = '0;
        snoop_wr_en   = '0;
        snoop_wr_addr = '0;
        snoop_wr_data = '0;

        // Reset with requests present: no grant, all outputs zero
        tick();
        #3;
        chk("rst_ready",  64'(req_ready), 64'h0);
        chk("rst_rden",   64'(ram_rd_en), 64'h0);
        chk("rst_raddr",  64'(ram_addr),  64'h0);
        chk("rst_rspv",   64'(rsp_valid), 64'h0);
        chk("rst_rspd",   64'(^rsp_data === 1'b0 && rsp_data == '0), 64'h1);
        tick();
        sync_rst  = 1'b0;
        req_valid = 8'h00;
        tick();

        // Single read by requester 3 at 0x10
        ra[3]     = 8'h10;
        req_valid = 8'h08;
        #3;
        chk("t1_ready", 64'(req_ready), 64'h08);
        chk("t1_rden",  64'(ram_rd_en), 64'h1);
        chk("t1_raddr", 64'(ram_addr),  64'h0010);
        tick();
        req_valid = 8'h00;
        #3;
        chk("t1_rspv_t1", 64'(rsp_valid), 64'h0);
        tick();
        #3;
        chk("t1_rspv_t2", 64'(rsp_valid), 64'h08);
        chk("t1_rspd",    rsp_data[3],    64'hDEAD);
        tick();
        #3;
        chk("t1_rspv_t3", 64'(rsp_valid), 64'h0);

        // All eight requesters for four cycles
        do_reset();
        for (int i = 0; i < 8; i++) ra[i] = 8'(8'h40 + i);
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 4) ? 8'hFF : 8'h00;
            #3;
            if (c < 4) begin
                exp_g = 8'h03 << (2 * c);
                lo    = 8'(8'h40 + 2 * c);
                chk($sformatf("t2_ready_c%0d", c), 64'(req_ready), 64'(exp_g));
                chk($sformatf("t2_raddr_c%0d", c), 64'(ram_addr), 64'({8'(lo + 8'd1), lo}));
            end
            if (c >= 2) begin
                exp_g = 8'h03 << (2 * (c - 2));
                chk($sformatf("t2_rspv_c%0d", c), 64'(rsp_valid), 64'(exp_g));
                chk($sformatf("t2_rspd0_c%0d", c), rsp_data[2 * (c - 2)],
                    64'h1040 + 64'(2 * (c - 2)));
                chk($sformatf("t2_rspd1_c%0d", c), rsp_data[2 * (c - 2) + 1],
                    64'h1041 + 64'(2 * (c - 2)));
            end
            tick();
        end
        req_valid = 8'hFF;
        #3;
        chk("t2_ptr_wrap", 64'(req_ready), 64'h03);
        tick();

        // Pointer at 5 with requesters 1 and 6
        do_reset();
        ra[4] = 8'h44;
        ra[1] = 8'h51;
        ra[6] = 8'h56;
        req_valid = 8'h10;
        #3;
        chk("t3_ready_a", 64'(req_ready), 64'h10);
        tick();
        req_valid = 8'h42;
        #3;
        chk("t3_ready_b", 64'(req_ready), 64'h42);
        chk("t3_raddr_b", 64'(ram_addr),  64'h5156);
        tick();
        req_valid = 8'hFF;
        #3;
        chk("t3_ptr2",   64'(req_ready), 64'h0C);
        chk("t3_rspv_c", 64'(rsp_valid), 64'h10);
        chk("t3_rspd4",  rsp_data[4],    64'h1044);
        tick();
        req_valid = 8'h00;
        #3;
        chk("t3_rspv_d", 64'(rsp_valid), 64'h42);
        chk("t3_rspd6",  rsp_data[6],    64'h1056);
        chk("t3_rspd1",  rsp_data[1],    64'h1051);
        tick();
        #3;
        chk("t3_rspv_e", 64'(rsp_valid), 64'h0C);
        tick();

        // Clock enable low for three cycles after issue
        do_reset();
        ra[3]     = 8'h10;
        req_valid = 8'h08;
        #3;
        chk("t4_ready", 64'(req_ready), 64'h08);
        tick();
        clk_en    = 1'b0;
        req_valid = 8'h01;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("t4_stall_rspv_%0d", c),  64'(rsp_valid), 64'h0);
            chk($sformatf("t4_stall_ready_%0d", c), 64'(req_ready), 64'h0);
            chk($sformatf("t4_stall_rden_%0d", c),  64'(ram_rd_en), 64'h0);
            tick();
        end
        clk_en    = 1'b1;
        req_valid = 8'h00;
        #3;
        chk("t4_rspv_en1", 64'(rsp_valid), 64'h0);
        tick();
        #3;
        chk("t4_rspv_en2", 64'(rsp_valid), 64'h08);
        chk("t4_rspd",     rsp_data[3],    64'hDEAD);
        tick();
        #3;
        chk("t4_rspv_en3", 64'(rsp_valid), 64'h0);

        // Reset one cycle after issue discards the read
        req_valid = 8'h08;
        #3;
        chk("t5_ready", 64'(req_ready), 64'h08);
        tick();
        sync_rst  = 1'b1;
        req_valid = 8'hFF;
        #3;
        chk("t5_rst_ready", 64'(req_ready), 64'h0);
        chk("t5_rst_rden",  64'(ram_rd_en), 64'h0);
        chk("t5_rst_rspv",  64'(rsp_valid), 64'h0);
        tick();
        sync_rst  = 1'b0;
        req_valid = 8'h00;
        #3;
        chk("t5_post_rspv", 64'(rsp_valid), 64'h0);
        chk("t5_post_rspd", 64'(rsp_data == '0), 64'h1);
        tick();
        #3;
        chk("t5_post2_rspv", 64'(rsp_valid), 64'h0);
        tick();

        // Writes to the read address one cycle after issue
        do_reset();
        ra[3]     = 8'h20;
        req_valid = 8'h08;
        #3;
        chk("t6_ready", 64'(req_ready), 64'h08);
        tick();
        req_valid        = 8'h00;
        snoop_wr_en      = 4'b1001;
        snoop_wr_addr[0] = 8'h20;
        snoop_wr_data[0] = 64'h5;
        snoop_wr_addr[3] = 8'h20;
        snoop_wr_data[3] = 64'h7;
        tick();
        snoop_wr_en = 4'b0000;
`ifdef REGFILE_RD_BYPASS_EN
        exp_byp = 64'h7;
`else
        exp_byp = 64'h1;
`endif
        #3;
        chk("t6_rspv", 64'(rsp_valid), 64'h08);
        chk("t6_rspd", rsp_data[3],    exp_byp);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
